merge_ctrl: RTL

Sequencing controller for the two-list index memory stage. Loads paired 8-bit index words into both list memories, then walks the two sorted lists with separate read pointers, emitting a single merged ascending stream under a valid/ready handshake. Sits directly upstream of the index memory stage, driving its write data, addresses and write enable, and consumes its two read words.

---
 rtl/merge_pkg.sv | 20 ++
 rtl/merge_ctrl_if.sv | 32 +++
 rtl/merge_ctrl_list_ptr.sv | 28 ++
 rtl/merge_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/merge_pkg.sv
// Shared constants, FSM state type and load payload for the two-list merge controller.
package merge_pkg;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MERGE,
        DONE
    } state_t;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } pair_t;

endpackage

// File: rtl/merge_ctrl_if.sv
// Control, load, memory-port and merged-output signals of merge_ctrl.
// The master modport is the controller's view; slave is the surrounding environment.
interface merge_ctrl_if;

    logic                        start;
    logic                        in_valid;
    logic [merge_pkg::DW-1:0]    in_a;
    logic [merge_pkg::DW-1:0]    in_b;
    logic [merge_pkg::DW-1:0]    i1;
    logic [merge_pkg::DW-1:0]    i2;
    logic [merge_pkg::AW-1:0]    cnt1;
    logic [merge_pkg::AW-1:0]    cnt2;
    logic                        wr_en;
    logic [merge_pkg::DW-1:0]    r1;
    logic [merge_pkg::DW-1:0]    r2;
    logic                        out_valid;
    logic                        out_ready;
    logic [merge_pkg::DW-1:0]    out_data;
    logic                        busy;
    logic                        done;

    modport master (
        input  start, in_valid, in_a, in_b, r1, r2, out_ready,
        output i1, i2, cnt1, cnt2, wr_en, out_valid, out_data, busy, done
    );

    modport slave (
        output start, in_valid, in_a, in_b, r1, r2, out_ready,
        input  i1, i2, cnt1, cnt2, wr_en, out_valid, out_data, busy, done
    );

endinterface

// File: rtl/merge_ctrl_list_ptr.sv
// Read pointer for one list: advances on request, wraps at DEPTH-1 and latches a sticky exhaust flag.
module list_ptr
    import merge_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    output logic [AW-1:0] ptr,
    output logic          exhausted
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            exhausted <= 1'b0;
        end else if (clear) begin
            ptr       <= '0;
            exhausted <= 1'b0;
        end else if (advance) begin
            ptr <= ptr + AW'(1);
            if (ptr == AW'(DEPTH - 1)) begin
                exhausted <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/merge_ctrl.sv
// Loads two sorted index lists into the index memories, then merges them into one ascending stream.
// Optional MERGE_DEDUP_EN: equal heads of two live lists are emitted once, consuming both.
module merge_ctrl
    import merge_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    merge_ctrl_if.master bus
);

    localparam int unsigned LCW = AW + 1;

    state_t         state;
    state_t         state_nx;
    logic [LCW-1:0] lc;
    logic [AW-1:0]  waddr;
    pair_t          wdata;
    logic           wr_en_q;
    logic           busy_q;
    logic           done_q;

    logic           clr;
    logic           load_take;
    logic           sel1;
    logic           sel2;
    logic           adv1;
    logic           adv2;
    logic           valid_c;
    logic           fin1;
    logic           fin2;
    logic [AW-1:0]  p1;
    logic [AW-1:0]  p2;
    logic           e1;
    logic           e2;

    list_ptr u_ptr1 (
        .clk      (clk),
        .reset    (reset),
        .clear    (clr),
        .advance  (adv1),
        .ptr      (p1),
        .exhausted(e1)
    );

    list_ptr u_ptr2 (
        .clk      (clk),
        .reset    (reset),
        .clear    (clr),
        .advance  (adv2),
        .ptr      (p2),
        .exhausted(e2)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, head selection and pointer advance
    always_comb begin
        state_nx  = state;
        clr       = 1'b0;
        load_take = 1'b0;
        sel1      = 1'b0;
        sel2      = 1'b0;
        adv1      = 1'b0;
        adv2      = 1'b0;
        valid_c   = 1'b0;
        fin1      = 1'b0;
        fin2      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = LOAD;
                    clr      = 1'b1;
                end
            end
            LOAD: begin
                // lc reaching DEPTH marks the cycle in which the last pair is written
                load_take = bus.in_valid && !lc[AW];
                if (lc[AW]) begin
                    state_nx = MERGE;
                end
            end
            MERGE: begin
                if (e1 && e2) begin
                    state_nx = DONE;
                end else begin
                    valid_c = 1'b1;
                    if (e1) begin
                        sel2 = 1'b1;
                    end else if (e2) begin
                        sel1 = 1'b1;
`ifdef MERGE_DEDUP_EN
                    end else if (bus.r1 == bus.r2) begin
                        sel1 = 1'b1;
                        sel2 = 1'b1;
`endif
                    end else if (bus.r1 <= bus.r2) begin
                        sel1 = 1'b1;
                    end else begin
                        sel2 = 1'b1;
                    end
                    adv1 = sel1 && bus.out_ready;
                    adv2 = sel2 && bus.out_ready;
                    fin1 = e1 || (adv1 && (p1 == AW'(DEPTH - 1)));
                    fin2 = e2 || (adv2 && (p2 == AW'(DEPTH - 1)));
                    if (fin1 && fin2) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Load counter, write-port registers and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lc      <= '0;
            waddr   <= '0;
            wdata   <= '0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            wr_en_q <= load_take;
            busy_q  <= (state_nx != IDLE);
            done_q  <= (state_nx == DONE);
            if (clr) begin
                lc <= '0;
            end else if (load_take) begin
                lc      <= lc + LCW'(1);
                waddr   <= lc[AW-1:0];
                wdata.a <= bus.in_a;
                wdata.b <= bus.in_b;
            end
        end
    end

    assign bus.i1        = wdata.a;
    assign bus.i2        = wdata.b;
    assign bus.wr_en     = wr_en_q;
    assign bus.cnt1      = (state == MERGE) ? p1 : waddr;
    assign bus.cnt2      = (state == MERGE) ? p2 : waddr;
    assign bus.out_valid = valid_c;
    assign bus.out_data  = !valid_c ? '0 : (sel1 ? bus.r1 : bus.r2);
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule
